mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter ALU_ADD_CTL, default 6'd32, ctl code driven to the shared ALU for add.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  request a multiply, sampled in IDLE only.
REQ-006 SHALL have port mcand  in  WIDTH  unsigned multiplicand, sampled with start.
REQ-007 SHALL have port mplier  in  WIDTH  unsigned multiplier, sampled with start.
REQ-008 SHALL have port busy  out  1  high while in RUN.
REQ-009 SHALL have port done  out  1  one-cycle pulse, result valid.
REQ-010 SHALL have port hi  out  WIDTH  upper product half.
REQ-011 SHALL have port lo  out  WIDTH  lower product half.
REQ-012 SHALL have port alu_ctl  out  6  ctl to the shared ALU.
REQ-013 SHALL have port alu_a  out  WIDTH  ALU operand a.
REQ-014 SHALL have port alu_b  out  WIDTH  ALU operand b.
REQ-015 SHALL have port alu_cin  out  1  ALU carry-in, always 0.
REQ-016 SHALL have port alu_result  in  WIDTH  ALU sum, combinational from alu_* outputs.
REQ-017 SHALL have port alu_carry  in  1  ALU carry-out of MSB.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after last iteration; DONE->IDLE unconditionally.
REQ-019 On start in IDLE: mcand latched, lo<=mplier, hi<=0, iteration count<=0, remaining-multiplier register<=mplier.
REQ-020 In RUN: alu_ctl=ALU_ADD_CTL, alu_a=hi, alu_b=(lo[0] ? latched mcand : 0), alu_cin=0.
REQ-021 Each RUN edge: hi<={alu_carry, alu_result[WIDTH-1:1]}, lo<={alu_result[0], lo[WIDTH-1:1]}, count+1, remaining-multiplier shifted right 1.
REQ-022 RUN SHALL last exactly WIDTH cycles; done high in DONE, exactly WIDTH+1 cycles after the start-sampling edge.
REQ-023 Outside RUN: alu_ctl=ALU_ADD_CTL, alu_a=0, alu_b=0, alu_cin=0.
REQ-024 start while in RUN or DONE SHALL be ignored; mcand/mplier changes after acceptance SHALL not affect the result.
REQ-025 hi/lo SHALL hold the product from DONE until the next accepted start.
REQ-026 Product SHALL be the exact 2*WIDTH-bit unsigned product; no overflow possible.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, hi=0, lo=0, busy=0, done=0, count=0, regardless of state; an in-flight multiply is discarded with no done pulse.

Configuration
REQ-028 Macro MUL_SEQ_EARLY_EXIT_EN defined: in RUN, when remaining-multiplier==0, that cycle SHALL not use the ALU result and SHALL set {hi,lo}<={hi,lo}>>(WIDTH-count), then go to DONE.
REQ-029 Macro MUL_SEQ_EARLY_EXIT_EN undefined: fixed WIDTH-cycle RUN per REQ-022; no remaining-multiplier register.

Structure
REQ-030 Package mul_seq_pkg SHALL hold the state enum and ALU ctl constants (add=32, sub=34, slt=42).
REQ-031 No sub-module; the ALU is external and shared, connected through alu_* ports.

Verification
REQ-032 mcand=3, mplier=5, start 1 cycle -> busy 32 cycles, done at cycle 33, hi=0, lo=15.
REQ-033 mcand=mplier=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; alu_carry observed 1 in some RUN cycle.
REQ-034 start pulsed again at RUN cycle 10 with mcand=7 -> ignored, first product unchanged, single done pulse.
REQ-035 rst_n low at RUN cycle 12 -> immediate IDLE, hi=lo=0, no done; next start completes normally.
REQ-036 With MUL_SEQ_EARLY_EXIT_EN: mplier=0 -> done 2 cycles after start, hi=lo=0; mcand=9, mplier=5 -> done 5 cycles after start, lo=45.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Package for the sequential multiplier controller (mul_seq_ctrl).
// Purpose : controller state encoding and the ctl codes of the shared ALU.
// Contents: state_t     - controller states IDLE / RUN / DONE
//           ALU_CTL_ADD - ALU ctl code for add (32)
//           ALU_CTL_SUB - ALU ctl code for subtract (34)
//           ALU_CTL_SLT - ALU ctl code for set-less-than (42)
package mul_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] ALU_CTL_ADD = 6'd32;
  localparam logic [5:0] ALU_CTL_SUB = 6'd34;
  localparam logic [5:0] ALU_CTL_SLT = 6'd42;

endpackage

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl - shift-and-add unsigned multiplier sequencer that borrows an
// external, shared ALU for its additions.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   request a multiply (sampled in IDLE only)
//   mcand       in   WIDTH unsigned multiplicand, sampled with start
//   mplier      in   WIDTH unsigned multiplier, sampled with start
//   busy        out  high while the multiply is running
//   done        out  one-cycle pulse, {hi,lo} holds the product
//   hi / lo     out  upper / lower product halves (held until the next start)
//   alu_ctl     out  6-bit ctl to the shared ALU (always the add code)
//   alu_a/alu_b out  ALU operands (zero outside RUN)
//   alu_cin     out  ALU carry-in, always 0
//   alu_result  in   combinational ALU sum of alu_a + alu_b
//   alu_carry   in   ALU carry-out of the MSB
//
// Build option: define MUL_SEQ_EARLY_EXIT_EN to finish early once the
// remaining multiplier bits are all zero; the default build always runs
// exactly WIDTH iterations.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int         WIDTH       = 32,
  parameter logic [5:0] ALU_ADD_CTL = ALU_CTL_ADD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [5:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  // Wide enough to hold WIDTH itself (needed for the early-exit shift amount).
  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [CW-1:0]    r_count;
  logic             w_last;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  // Multiplier bits not yet consumed; once zero, every further iteration
  // would only shift {hi,lo} right, so that shift is done in one step.
  logic [WIDTH-1:0]   r_rem;
  logic               w_exit;
  logic [2*WIDTH-1:0] w_exit_prod;

  assign w_exit      = (r_rem == '0);
  assign w_exit_prod = {r_hi, r_lo} >> (CW'(WIDTH) - r_count);
  assign w_last      = w_exit || (r_count == CW'(WIDTH - 1));
`else
  assign w_last      = (r_count == CW'(WIDTH - 1));
`endif

  // ---------------------------------------------------------------- state
  // NOTE: every clocked register uses non-blocking (<=) assignments so all
  // flops update together from pre-edge values; blocking here would chain
  // the updates and break simulation/synthesis equivalence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ----------------------------------------------------------- next state
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    alu_ctl = ALU_ADD_CTL;
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    unique case (r_state)
      S_RUN: begin
        busy  = 1'b1;
        alu_a = r_hi;
        alu_b = r_lo[0] ? r_mcand : '0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_count <= '0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
      r_rem   <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && start) begin
        r_mcand <= mcand;
        r_hi    <= '0;
        r_lo    <= mplier;
        r_count <= '0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
        r_rem   <= mplier;
`endif
      end else if (r_state == S_RUN) begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
        if (w_exit) begin
          {r_hi, r_lo} <= w_exit_prod;
        end else begin
          r_hi <= {alu_carry, alu_result[WIDTH-1:1]};
          r_lo <= {alu_result[0], r_lo[WIDTH-1:1]};
        end
        r_rem <= r_rem >> 1;
`else
        // Sum's carry and upper bits become hi; its LSB is a finished
        // product bit that enters lo from the top as lo shifts out mplier.
        r_hi <= {alu_carry, alu_result[WIDTH-1:1]};
        r_lo <= {alu_result[0], r_lo[WIDTH-1:1]};
`endif
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl. The shared ALU is modelled as a plain
// adder; expected products come from native 2*WIDTH-bit multiplication and
// expected latencies from the multiplier value.
module tb_mul_seq_ctrl;

  localparam int         W      = 32;
  localparam logic [5:0] ADD    = 6'd32;
  localparam int         BUDGET = 100;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic           busy, done, alu_cin, alu_carry;
  logic [W-1:0]   hi, lo, alu_a, alu_b, alu_result;
  logic [5:0]     alu_ctl;

  int n_tests = 0;
  int n_fail  = 0;

  mul_seq_ctrl #(.WIDTH(W), .ALU_ADD_CTL(ADD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  // External shared ALU: combinational add with carry-out.
  assign {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Cycle (counted from the start-sampling edge) in which done must be high.
  function automatic int exp_latency(input logic [W-1:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    int k;
    k = 0;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    if (k == W) return W + 1;
    return k + 2;
`else
    return W + 1;
`endif
  endfunction

  function automatic logic [2*W-1:0] product(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] pa, pb;
    pa = {{W{1'b0}}, a};
    pb = {{W{1'b0}}, b};
    return pa * pb;
  endfunction

  // Launch one multiply and observe it. Inputs are scrambled right after
  // acceptance; optionally re-pulse start (mcand=7) at RUN cycle poke_cyc.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int poke_cyc,
                         output int done_cyc, output int busy_cyc, output int extra_pulses,
                         output int ctl_err, output logic carry_seen,
                         output logic [2*W-1:0] res, output logic [2*W-1:0] held);
    start = 1'b1; mcand = a; mplier = b;
    @(posedge clk); #1;
    start = 1'b0; mcand = $urandom; mplier = $urandom;
    done_cyc = -1; busy_cyc = 0; extra_pulses = 0; ctl_err = 0;
    carry_seen = 1'b0; res = 'x;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        res = {hi, lo};
        break;
      end
      if (busy === 1'b1) begin
        busy_cyc++;
        if (alu_carry === 1'b1) carry_seen = 1'b1;
        if (alu_ctl !== ADD || alu_cin !== 1'b0) ctl_err++;
      end
      if (cyc == poke_cyc) begin
        start = 1'b1; mcand = 7; mplier = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra_pulses++;
    end
    held = {hi, lo};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: busy,done=%b required 00", {busy, done});
    end
    n_tests++;
    if ({hi, lo} !== '0) begin
      n_fail++; $display("FAIL reset_product: got %h required 0", {hi, lo});
    end
    n_tests++;
    if (alu_ctl !== ADD || alu_a !== '0 || alu_b !== '0 || alu_cin !== 1'b0) begin
      n_fail++; $display("FAIL reset_alu: ctl=%0d a=%h b=%h cin=%b required 32/0/0/0",
                         alu_ctl, alu_a, alu_b, alu_cin);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Common checks for one multiply; each call site supplies its own label.
  task automatic test_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke_cyc, input logic want_carry);
    int done_cyc, busy_cyc, extra, ctl_err;
    logic carry_seen;
    logic [2*W-1:0] res, held, exp;
    exp = product(a, b);
    run_mul(a, b, poke_cyc, done_cyc, busy_cyc, extra, ctl_err, carry_seen, res, held);
    n_tests++;
    if (done_cyc != exp_latency(b)) begin
      n_fail++; $display("FAIL %s_latency: done in cycle %0d required %0d", name, done_cyc, exp_latency(b));
    end
    n_tests++;
    if (busy_cyc != exp_latency(b) - 1) begin
      n_fail++; $display("FAIL %s_busy: busy for %0d cycles required %0d", name, busy_cyc, exp_latency(b) - 1);
    end
    n_tests++;
    if (res !== exp) begin
      n_fail++; $display("FAIL %s_product: %0d*%0d got %h required %h", name, a, b, res, exp);
    end
    n_tests++;
    if (extra != 0 || held !== exp) begin
      n_fail++; $display("FAIL %s_hold: extra done pulses %0d, held %h required 0 pulses, %h",
                         name, extra, held, exp);
    end
    n_tests++;
    if (ctl_err != 0) begin
      n_fail++; $display("FAIL %s_alu_ctl: %0d RUN cycles with wrong ctl/cin, required 0", name, ctl_err);
    end
    if (want_carry) begin
      n_tests++;
      if (carry_seen !== 1'b1) begin
        n_fail++; $display("FAIL %s_carry: alu_carry never 1 in RUN, required at least once", name);
      end
    end
    n_tests++;
    if (busy !== 1'b0 || alu_a !== '0 || alu_b !== '0) begin
      n_fail++; $display("FAIL %s_idle_alu: busy=%b a=%h b=%h required 0/0/0", name, busy, alu_a, alu_b);
    end
  endtask

  task automatic test_basic();
    test_mul("basic_3x5", 32'd3, 32'd5, -1, 1'b0);
  endtask

  task automatic test_max();
    test_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) b = 32'h0000_0001;
      if (i == 1) a = '0;
      test_mul("random", a, b, -1, 1'b0);
    end
  endtask

  task automatic test_ignore_start();
    // MSB set keeps the multiply in RUN at cycle 10 in every build.
    test_mul("ignore_start", 32'd1234, 32'h8000_0ABC, 10, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    start = 1'b1; mcand = $urandom; mplier = 32'h8000_0000 | $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_precond: busy=%b at RUN cycle 12 required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done} !== 2'b00 || {hi, lo} !== '0) begin
      n_fail++; $display("FAIL midrst_immediate: busy=%b done=%b prod=%h required 0/0/0", busy, done, {hi, lo});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL midrst_no_done: %0d cycles with busy/done after reset, required 0", pulses);
    end
    test_mul("after_reset", $urandom, $urandom, -1, 1'b0);
  endtask

`ifdef MUL_SEQ_EARLY_EXIT_EN
  task automatic test_early_exit();
    test_mul("early_zero", 32'd77, 32'd0, -1, 1'b0);
    test_mul("early_9x5", 32'd9, 32'd5, -1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_random();
    test_ignore_start();
    test_reset_mid_run();
`ifdef MUL_SEQ_EARLY_EXIT_EN
    test_early_exit();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
